// File: rtl/rx_frame_buffer.sv
// Receive frame buffer: filters deframed bytes into a circular RAM, commits or drops each
// frame at its end marker (FCS stripped) and streams committed frames to the host.
module rx_frame_buffer #(
    parameter int DEPTH   = 256,
    parameter int AW      = 8,
    parameter int NFRAMES = 4,
    parameter int MAX_LEN = 1280
) (
    input  logic        netclk,
    input  logic        reset,
    input  logic        byte_ready,
    input  logic [7:0]  din,
    input  logic        frame_complete,
    input  logic        frame_valid,
    input  logic        frame_abort,
    input  logic [7:0]  my_station,
    input  logic        promisc,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        rd_last,
    input  logic        rd_ready,
    output logic [AW:0] frames_pending,
    output logic        drop_pulse,
    output logic [1:0]  drop_reason
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int FW = $clog2(NFRAMES);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
    localparam logic [FW:0]   LF_FULL  = (FW + 1)'(NFRAMES);
    localparam logic [FW:0]   LF_ONE   = (FW + 1)'(1);
    localparam logic [CW-1:0] LEN_MAX  = CW'(MAX_LEN);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DISCARD} wr_state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [CW-1:0] r_lf_mem [NFRAMES];
    wr_state_t     r_state;
    logic          r_byte_q, r_end_q, r_abort_q;
    logic [AW:0]   r_wr_ptr, r_frame_start, r_rd_ptr;
    logic [CW-1:0] r_cnt, r_pos;
    logic [FW:0]   r_lf_wr, r_lf_rd;
    logic          r_err_pend;
    logic [1:0]    r_err_reason;
    logic          r_drop_pulse;
    logic [1:0]    r_drop_reason;
    logic [7:0]    r_rd_data;
    logic          r_rd_valid, r_rd_last;

    logic          w_byte_ev, w_end_ev, w_abort_ev;
    logic          w_pass, w_full, w_byte_err, w_we, w_lf_full, w_end_ok;
    logic          w_xfer, w_load;
    logic [1:0]    w_byte_reason, w_end_reason;
    logic [CW-1:0] w_cnt_n, w_len, w_head_len, w_load_idx;
    logic [FW:0]   w_lf_cnt;
    logic [AW-1:0] w_fetch;

    assign w_byte_ev     = byte_ready & ~r_byte_q;
    assign w_end_ev      = frame_complete & ~r_end_q;
    assign w_abort_ev    = frame_abort & ~r_abort_q;
    assign w_pass        = (din == my_station) | (din == 8'hFF) | promisc;
    assign w_full        = (r_wr_ptr - r_rd_ptr) == FULL_LVL;
    assign w_byte_err    = w_full | (r_cnt == LEN_MAX);
    assign w_byte_reason = w_full ? 2'd2 : 2'd1;
    assign w_cnt_n       = r_cnt + (w_byte_ev ? CW'(1) : CW'(0));
    assign w_len         = w_cnt_n - CW'(2);
    assign w_lf_cnt      = r_lf_wr - r_lf_rd;
    assign w_lf_full     = w_lf_cnt == LF_FULL;
    assign w_we          = w_byte_ev & ~w_full &
                           (((r_state == S_IDLE) & w_pass) | ((r_state == S_RECV) & (r_cnt != LEN_MAX)));

    // End-of-frame verdict; a byte arriving with the end marker is counted first
    always_comb begin
        w_end_ok     = 1'b0;
        w_end_reason = 2'd2;
        if (w_byte_ev && w_byte_err)  w_end_reason = w_byte_reason;
        else if (w_cnt_n < CW'(4))    w_end_reason = 2'd1;
        else if (!frame_valid)        w_end_reason = 2'd0;
        else if (w_lf_full)           w_end_reason = 2'd2;
        else                          w_end_ok     = 1'b1;
    end

    always_ff @(posedge netclk) begin
        if (w_we) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge netclk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_byte_q      <= 1'b0;
            r_end_q       <= 1'b0;
            r_abort_q     <= 1'b0;
            r_wr_ptr      <= '0;
            r_frame_start <= '0;
            r_cnt         <= '0;
            r_lf_wr       <= '0;
            r_err_pend    <= 1'b0;
            r_err_reason  <= '0;
            r_drop_pulse  <= 1'b0;
            r_drop_reason <= '0;
        end else begin
            r_byte_q     <= byte_ready;
            r_end_q      <= frame_complete;
            r_abort_q    <= frame_abort;
            r_drop_pulse <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_byte_ev) begin
                        r_frame_start <= r_wr_ptr;
                        r_cnt         <= CW'(1);
                        if (!w_pass) begin
                            r_err_pend <= 1'b0;
                            r_state    <= S_DISCARD;
                        end else if (w_full) begin
                            r_err_pend   <= 1'b1;
                            r_err_reason <= 2'd2;
                            r_state      <= S_DISCARD;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + PTR_ONE;
                            r_state  <= S_RECV;
                        end
                    end
                end
                S_RECV: begin
                    if (w_abort_ev) begin
                        r_wr_ptr      <= r_frame_start;
                        r_drop_pulse  <= 1'b1;
                        r_drop_reason <= 2'd3;
                        r_state       <= S_IDLE;
                    end else if (w_end_ev) begin
                        r_state <= S_IDLE;
                        if (w_end_ok) begin
                            r_lf_mem[r_lf_wr[FW-1:0]] <= w_len;
                            r_lf_wr  <= r_lf_wr + LF_ONE;
                            r_wr_ptr <= r_frame_start + (AW + 1)'(w_len);
                        end else begin
                            r_wr_ptr      <= r_frame_start;
                            r_drop_pulse  <= 1'b1;
                            r_drop_reason <= w_end_reason;
                        end
                    end else if (w_byte_ev) begin
                        if (w_byte_err) begin
                            r_err_pend   <= 1'b1;
                            r_err_reason <= w_byte_reason;
                            r_state      <= S_DISCARD;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + PTR_ONE;
                            r_cnt    <= w_cnt_n;
                        end
                    end
                end
                S_DISCARD: begin
                    if (w_end_ev || w_abort_ev) begin
                        r_wr_ptr   <= r_frame_start;
                        r_state    <= S_IDLE;
                        r_err_pend <= 1'b0;
                        if (r_err_pend) begin
                            r_drop_pulse  <= 1'b1;
                            r_drop_reason <= r_err_reason;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output register is refilled from rd_ptr, or from the byte after it when the held byte
    // is leaving this cycle; rd_ptr itself only moves on a transfer, so the held byte's slot
    // stays reserved until the host takes it.
    assign w_xfer     = r_rd_valid & rd_ready;
    assign w_load     = (w_lf_cnt != '0) & (~r_rd_valid | (w_xfer & ~r_rd_last));
    assign w_head_len = r_lf_mem[r_lf_rd[FW-1:0]];
    assign w_fetch    = r_rd_ptr[AW-1:0] + (r_rd_valid ? AW'(1) : AW'(0));
    assign w_load_idx = r_pos + (r_rd_valid ? CW'(2) : CW'(1));

    always_ff @(posedge netclk) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_pos      <= '0;
            r_lf_rd    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_rd_ptr   <= r_rd_ptr + PTR_ONE;
                r_rd_valid <= 1'b0;
                r_rd_last  <= 1'b0;
                if (r_rd_last) begin
                    r_pos   <= '0;
                    r_lf_rd <= r_lf_rd + LF_ONE;
                end else begin
                    r_pos <= r_pos + CW'(1);
                end
            end
            if (w_load) begin
                r_rd_data  <= r_mem[w_fetch];
                r_rd_valid <= 1'b1;
                r_rd_last  <= (w_load_idx == w_head_len);
            end
        end
    end

    assign rd_data        = r_rd_data;
    assign rd_valid       = r_rd_valid;
    assign rd_last        = r_rd_last;
    assign frames_pending = (AW + 1)'(w_lf_cnt);
    assign drop_pulse     = r_drop_pulse;
    assign drop_reason    = r_drop_reason;

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Bench for rx_frame_buffer: directed scenarios plus random frames and host backpressure,
// checked against a frame-level queue model of accepted bytes and drop reasons.
module tb_rx_frame_buffer;
    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int NFRAMES = 4;
    localparam int MAX_LEN = 12;

    logic        netclk = 1'b0;
    logic        reset = 1'b1;
    logic        byte_ready = 1'b0;
    logic [7:0]  din = '0;
    logic        frame_complete = 1'b0;
    logic        frame_valid = 1'b0;
    logic        frame_abort = 1'b0;
    logic [7:0]  my_station = 8'h12;
    logic        promisc = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_last;
    logic        rd_ready = 1'b0;
    logic [AW:0] frames_pending;
    logic        drop_pulse;
    logic [1:0]  drop_reason;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;
    typedef logic [7:0] bq_t[$];

    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];
    int         exp_drop[$];
    logic [7:0] log_data[$];
    logic       log_last[$];
    int         drops_seen = 0;
    int         last_drop = -1;
    int         ready_mode = 0;
    int         idle_cyc = 0;

    rx_frame_buffer #(
        .DEPTH(DEPTH),
        .AW(AW),
        .NFRAMES(NFRAMES),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .netclk(netclk),
        .reset(reset),
        .byte_ready(byte_ready),
        .din(din),
        .frame_complete(frame_complete),
        .frame_valid(frame_valid),
        .frame_abort(frame_abort),
        .my_station(my_station),
        .promisc(promisc),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .rd_last(rd_last),
        .rd_ready(rd_ready),
        .frames_pending(frames_pending),
        .drop_pulse(drop_pulse),
        .drop_reason(drop_reason)
    );

    always #5 netclk = ~netclk;

    task automatic tick();
        @(posedge netclk);
        #1;
    endtask

    function automatic int model_pending();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i].last) n++;
        return n;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Host-side ready driver
    initial begin
        forever begin
            @(posedge netclk);
            #1;
            case (ready_mode)
                0:       rd_ready = 1'b0;
                1:       rd_ready = 1'b1;
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge netclk);
            if (reset) begin
                idle_cyc = 0;
            end else begin
                checks++;
                if (int'(frames_pending) != model_pending()) begin
                    errors++;
                    $display("FAIL frames_pending: got %0d required %0d", frames_pending, model_pending());
                end
                if (exp_q.size() != 0 && !rd_valid) begin
                    idle_cyc++;
                    checks++;
                    if (idle_cyc > 2) begin
                        errors++;
                        $display("FAIL rd_valid_latency: idle %0d cycles with data pending", idle_cyc);
                    end
                end else begin
                    idle_cyc = 0;
                end
                if (rd_valid) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rd_unexpected: got data %h last %b required no valid", rd_data, rd_last);
                    end else begin
                        if (rd_data !== exp_q[0].data || rd_last !== exp_q[0].last) begin
                            errors++;
                            $display("FAIL rd_stream: got %h/%b required %h/%b",
                                     rd_data, rd_last, exp_q[0].data, exp_q[0].last);
                        end
                        if (rd_ready) begin
                            log_data.push_back(rd_data);
                            log_last.push_back(rd_last);
                            void'(exp_q.pop_front());
                        end
                    end
                end
                if (drop_pulse) begin
                    checks++;
                    drops_seen++;
                    last_drop = int'(drop_reason);
                    if (exp_drop.size() == 0) begin
                        errors++;
                        $display("FAIL drop_unexpected: got reason %0d required no drop", drop_reason);
                    end else begin
                        if (int'(drop_reason) != exp_drop[0]) begin
                            errors++;
                            $display("FAIL drop_reason: got %0d required %0d", drop_reason, exp_drop[0]);
                        end
                        void'(exp_drop.pop_front());
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit hold2);
        din = b;
        byte_ready = 1'b1;
        tick();
        if (hold2) tick();
        byte_ready = 1'b0;
        tick();
    endtask

    // endk: 0 = end with good FCS, 1 = end with bad FCS, 2 = abort
    task automatic send_frame(input bq_t fr, input int endk, input bit hold2);
        int   stored = 0;
        int   reason = -1;
        int   unread;
        bit   filt;
        exp_t e;
        for (int i = 0; i < fr.size(); i++) send_byte(fr[i], hold2);
        unread = exp_q.size();
        filt = !(fr[0] == my_station || fr[0] == 8'hFF || promisc);
        if (!filt) begin
            for (int i = 0; i < fr.size(); i++) begin
                if (unread + stored == DEPTH) begin reason = 2; break; end
                if (stored == MAX_LEN) begin reason = 1; break; end
                stored++;
            end
            if (reason < 0) begin
                if (endk == 2)                         reason = 3;
                else if (stored < 4)                   reason = 1;
                else if (endk == 1)                    reason = 0;
                else if (model_pending() == NFRAMES)   reason = 2;
            end
        end
        if (endk == 2) begin
            frame_abort = 1'b1;
        end else begin
            frame_complete = 1'b1;
            frame_valid = (endk == 0);
        end
        tick();
        if (!filt) begin
            if (reason >= 0) begin
                exp_drop.push_back(reason);
            end else begin
                for (int i = 0; i < stored - 2; i++) begin
                    e.data = fr[i];
                    e.last = (i == stored - 3);
                    exp_q.push_back(e);
                end
            end
        end
        frame_abort = 1'b0;
        frame_complete = 1'b0;
        frame_valid = 1'b0;
        tick();
        tick();
        check("drop_missing", exp_drop.size(), 0);
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while ((exp_q.size() != 0 || rd_valid) && n < maxc) begin
            tick();
            n++;
        end
        check("drain_done", (exp_q.size() == 0 && !rd_valid) ? 1 : 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_valid"}, int'(rd_valid), 0);
        check({tag, "_rd_last"}, int'(rd_last), 0);
        check({tag, "_rd_data"}, int'(rd_data), 0);
        check({tag, "_pending"}, int'(frames_pending), 0);
        check({tag, "_drop_pulse"}, int'(drop_pulse), 0);
        check({tag, "_drop_reason"}, int'(drop_reason), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        bq_t        f;
        logic [7:0] t1[4];
        int         d0;
        int         len;
        int         n;
        int         r;

        reset = 1'b1;
        tick();
        tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        tick();

        // 1: good frame, FCS stripped
        ready_mode = 0;
        f = '{8'h12, 8'h34, 8'hAA, 8'hBB, 8'hF1, 8'hF2};
        send_frame(f, 0, 1'b0);
        check("t1_pending_one", int'(frames_pending), 1);
        log_data.delete();
        log_last.delete();
        ready_mode = 1;
        wait_drain(100);
        t1 = '{8'h12, 8'h34, 8'hAA, 8'hBB};
        check("t1_count", log_data.size(), 4);
        if (log_data.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t1_byte", int'(log_data[i]), int'(t1[i]));
                check("t1_last", int'(log_last[i]), (i == 3) ? 1 : 0);
            end
        end
        check("t1_pending_zero", int'(frames_pending), 0);

        // 2: bad FCS
        d0 = drops_seen;
        send_frame(f, 1, 1'b0);
        check("t2_drop_count", drops_seen, d0 + 1);
        check("t2_drop_reason", last_drop, 0);
        check("t2_rd_valid", int'(rd_valid), 0);

        // 3: destination filtering
        d0 = drops_seen;
        log_data.delete();
        log_last.delete();
        f = '{8'h34, 8'h01, 8'h02, 8'h03, 8'hF1, 8'hF2};
        send_frame(f, 0, 1'b0);
        tick();
        tick();
        check("t3_filtered_nodrop", drops_seen, d0);
        check("t3_filtered_noout", log_data.size(), 0);
        f = '{8'hFF, 8'h01, 8'h02, 8'h03, 8'hF1, 8'hF2};
        send_frame(f, 0, 1'b0);
        wait_drain(100);
        check("t3_bcast_count", log_data.size(), 4);
        promisc = 1'b1;
        f = '{8'h34, 8'h05, 8'h06, 8'hF1, 8'hF2};
        send_frame(f, 0, 1'b0);
        wait_drain(100);
        promisc = 1'b0;
        check("t3_promisc_count", log_data.size(), 7);
        if (log_data.size() == 7) check("t3_promisc_first", int'(log_data[4]), 'h34);

        // 4: RAM overflow and length-FIFO overflow
        ready_mode = 0;
        log_data.delete();
        log_last.delete();
        d0 = drops_seen;
        f = '{8'h12, 8'hA0, 8'hA1, 8'hA2, 8'hF1, 8'hF2};
        send_frame(f, 0, 1'b0);
        f.delete();
        for (int i = 0; i < 20; i++) f.push_back((i == 0) ? 8'h12 : 8'(i));
        send_frame(f, 0, 1'b0);
        check("t4_ovf_count", drops_seen, d0 + 1);
        check("t4_ovf_reason", last_drop, 2);
        ready_mode = 1;
        wait_drain(100);
        check("t4_first_len", log_data.size(), 4);
        if (log_data.size() == 4) check("t4_first_byte3", int'(log_data[3]), 'hA2);
        ready_mode = 0;
        d0 = drops_seen;
        for (int k = 0; k < NFRAMES + 1; k++) begin
            f = '{8'h12, 8'(8'h40 + k), 8'hF1, 8'hF2};
            send_frame(f, 0, 1'b0);
        end
        check("t4_fifo_drop_count", drops_seen, d0 + 1);
        check("t4_fifo_reason", last_drop, 2);
        check("t4_fifo_pending", int'(frames_pending), NFRAMES);
        ready_mode = 1;
        wait_drain(200);

        // 5: abort, then a good frame with stretched byte strobes; long frame
        log_data.delete();
        log_last.delete();
        f = '{8'h12, 8'h01, 8'h02};
        send_frame(f, 2, 1'b0);
        check("t5_abort_reason", last_drop, 3);
        f = '{8'h12, 8'h55, 8'h66, 8'hF1, 8'hF2};
        send_frame(f, 0, 1'b1);
        wait_drain(100);
        check("t5_count", log_data.size(), 3);
        if (log_data.size() == 3) check("t5_byte2", int'(log_data[2]), 'h66);
        f.delete();
        for (int i = 0; i < MAX_LEN + 2; i++) f.push_back((i == 0) ? 8'h12 : 8'(i));
        send_frame(f, 0, 1'b0);
        check("t5_long_reason", last_drop, 1);

        // 6: runt, then reset mid-frame and mid-read
        f = '{8'h12, 8'h01, 8'h02};
        send_frame(f, 0, 1'b0);
        check("t6_runt_reason", last_drop, 1);
        ready_mode = 0;
        f = '{8'h12, 8'h77, 8'h88, 8'h99, 8'hF1, 8'hF2};
        send_frame(f, 0, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h01, 1'b0);
        reset = 1'b1;
        tick();
        check_reset_outputs("t6_rst");
        exp_q.delete();
        exp_drop.delete();
        reset = 1'b0;
        tick();
        log_data.delete();
        log_last.delete();
        ready_mode = 1;
        f = '{8'h12, 8'hC1, 8'hC2, 8'hF1, 8'hF2};
        send_frame(f, 0, 1'b0);
        wait_drain(100);
        check("t6_after_count", log_data.size(), 3);
        if (log_data.size() == 3) check("t6_after_byte1", int'(log_data[1]), 'hC1);

        // 7: random frames with random backpressure
        ready_mode = 2;
        for (int k = 0; k < 40; k++) begin
            len = $urandom_range(2, MAX_LEN + 2);
            f.delete();
            r = $urandom_range(0, 3);
            f.push_back((r < 2) ? my_station : ((r == 2) ? 8'hFF : 8'h34));
            for (int i = 1; i < len; i++) f.push_back(8'($urandom));
            n = 0;
            while ((exp_q.size() + len > DEPTH || model_pending() >= NFRAMES) && n < 2000) begin
                tick();
                n++;
            end
            check("t7_space_wait", (n < 2000) ? 1 : 0, 1);
            r = $urandom_range(0, 9);
            send_frame(f, (r < 7) ? 0 : ((r < 9) ? 1 : 2), 1'($urandom_range(0, 1)));
        end
        ready_mode = 1;
        wait_drain(500);
        check("final_drops_left", exp_drop.size(), 0);
        check("final_pending", int'(frames_pending), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
